bch_chien_seq: RTL
==================

// Module: bch_chien_seq
// PURPOSE
//  Sequential, parametrised Chien search for binary BCH decoders over GF(2^M), code length N=2^M-1.
//  Takes error-locator coefficients lambda_1..lambda_T (lambda_0=1) from the Berlekamp-Massey stage.
//  Evaluates P code positions per cycle and returns the full error vector, root count and uncorrectable flag.
//  Successor to the combinational bch_31 Chien (M=5, T=2). Sits between key-equation solver and correction XOR.
// PARAMETERS
//  M          5      field degree; N = 2**M-1
//  T          2      correction capability = number of lambda coefficients (T >= 1)
//  P          1      positions evaluated per cycle (1 <= P <= N)
//  PRIM_POLY  'h25   primitive polynomial incl. x^M term (x^5+x^2+1)
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         synchronous, active-high reset
//  in_valid       in   1         lambda word valid
//  in_ready       out  1         block idle, accepts lambda
//  lambda         in   T*M       lambda_i at [i*M-1 -: M], i=1..T
//  out_valid      out  1         result valid, held until out_ready
//  out_ready      in   1         downstream accepts result
//  error_vector   out  N         bit j set iff Lambda(alpha^-j)==0, j=0..N-1
//  error_found    out  1         |error_vector
//  err_count      out  $clog2(N+1)  number of set bits in error_vector
//  uncorrectable  out  1         err_count != deg(Lambda)
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; error_vector, error_found, err_count, uncorrectable all 0.
//  - FSM IDLE -> SEARCH on in_valid&&in_ready; SEARCH -> DONE after S=ceil(N/P) cycles; DONE -> IDLE on out_ready.
//  - in_ready = (state==IDLE) only; no accept in SEARCH or DONE, no same-cycle bypass DONE->accept.
//  - Accept: reg_i <= lambda_i; deg <= highest i with lambda_i!=0 (0 if all zero); vector/count cleared.
//  - SEARCH step k (0..S-1): lane p evaluates j=k*P+p: sum = 1 ^ XOR_i(reg_i * alpha^(-i*p)).
//    sum==0 sets bit j and increments count. Lanes with j>=N masked (no bit, no count).
//    Then reg_i <= reg_i * alpha^(-i*P). All multiplies by constants; alpha^-1 = alpha^(N-1).
//  - Latency: accept edge at cycle 0 -> out_valid high from cycle S+1. P=1,M=5: S=31; P=4: S=8.
//  - DONE: out_valid=1, all result outputs stable while out_ready=0 (arbitrary stall).
//  - Handshake edge at out_valid&&out_ready: next cycle out_valid=0, in_ready=1; result outputs keep last value.
//  - uncorrectable = (count != deg); registered with out_valid. All-zero lambda: deg 0, count 0, flags 0.
//  - Repeated roots count once (bit per position), so a square factor raises uncorrectable.
//  - in_valid in SEARCH/DONE ignored; lambda only sampled on accept edge.
//  - rst at any cycle (mid-SEARCH, in DONE) overrides everything: next cycle = reset values.
//  - err_count saturates never: max N fits $clog2(N+1) bits.
// STRUCTURE
//  - Package bch_pkg: localparam N(M); function gf_mul(a,b,M,PRIM_POLY); function gf_alpha_pow(e) ->
//    element; typedef state_t {IDLE,SEARCH,DONE}; function popcount for P-lane hit vector.
//  - Sub-module gf_const_mul (M, PRIM_POLY, CONST_EXP): combinational multiply by alpha^CONST_EXP;
//    instantiated per (i,p) lane and per reg_i update.
//  - Top: FSM, step counter (0..S-1), T coefficient regs, P evaluation lanes, vector/count accumulators.
// TESTING (M=5, PRIM_POLY='h25 unless stated)
//  1. P=1, lambda1=8 (alpha^3), lambda2=0 -> after 32 cycles: vector bit 3 only, count 1, found 1, uncorr 0.
//  2. P=1, lambda1=1, lambda2=20 (errors at 2,5) -> bits 2 and 5, count 2, uncorr 0.
//  3. P=1, lambda1=0, lambda2=1 (Lambda=(1+x)^2) -> bit 0 only, count 1, deg 2 -> uncorr 1.
//  4. lambda=0 -> vector 0, found 0, count 0, uncorr 0; out_ready low 5 cycles -> outputs stable, in_ready 0.
//  5. P=4 repeat 1-3 -> identical results, out_valid at cycle 9; P=31 -> out_valid at cycle 2.
//  6. rst pulse at search step 10 then new lambda (test 2) -> reset values next cycle, clean correct result.

Source files
------------

// File: rtl/bch_chien_seq_pkg.sv
// Shared GF(2^M) helpers, FSM state type and hit-vector popcount for the
// sequential Chien search.
package bch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Widest lane-hit vector the popcount helper accepts (P <= POP_W).
    localparam int POP_W = 256;

    function automatic int bch_n(input int m);
        return (1 << m) - 1;
    endfunction

    // Polynomial-basis multiply in GF(2^m), reducing by prim_poly (x^m term included).
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                           input int m, input logic [31:0] prim_poly);
        logic [31:0] acc;
        logic [31:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 32; i++) begin
            if (i < m) begin
                if (b[i]) acc = acc ^ x;
                x = x << 1;
                if (x[m]) x = x ^ prim_poly;
            end
        end
        return acc;
    endfunction

    // alpha^e for any integer e; negative exponents wrap modulo N.
    function automatic logic [31:0] gf_alpha_pow(input int e, input int m,
                                                 input logic [31:0] prim_poly);
        int          n;
        int          r_e;
        logic [31:0] r;
        n   = bch_n(m);
        r_e = e % n;
        if (r_e < 0) r_e = r_e + n;
        r = 32'd1;
        for (int k = 0; k < r_e; k++) r = gf_mul(r, 32'd2, m, prim_poly);
        return r;
    endfunction

    function automatic int popcount(input logic [POP_W-1:0] bits);
        int c;
        c = 0;
        for (int i = 0; i < POP_W; i++) begin
            if (bits[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/bch_chien_seq_if.sv
// Lambda-in / error-vector-out handshake bundle of the Chien search block.
interface bch_chien_seq_if
    import bch_pkg::*;
#(
    parameter int M = 5,
    parameter int T = 2
) ();
    localparam int N  = bch_n(M);
    localparam int CW = $clog2(N + 1);

    logic            in_valid;
    logic            in_ready;
    logic [T*M-1:0]  lambda;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    error_vector;
    logic            error_found;
    logic [CW-1:0]   err_count;
    logic            uncorrectable;

    modport master (
        output in_valid, lambda, out_ready,
        input  in_ready, out_valid, error_vector, error_found, err_count, uncorrectable
    );

    modport slave (
        input  in_valid, lambda, out_ready,
        output in_ready, out_valid, error_vector, error_found, err_count, uncorrectable
    );

endinterface

// File: rtl/bch_chien_seq_gf_const_mul.sv
// Combinational multiply of a GF(2^M) element by the constant alpha^CONST_EXP.
module gf_const_mul
    import bch_pkg::*;
#(
    parameter int          M         = 5,
    parameter logic [31:0] PRIM_POLY = 32'h25,
    parameter int          CONST_EXP = 0
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);
    localparam logic [31:0] C = gf_alpha_pow(CONST_EXP, M, PRIM_POLY);

    assign y = M'(gf_mul(32'(a), C, M, PRIM_POLY));

endmodule

// File: rtl/bch_chien_seq.sv
// Sequential Chien search: P positions per cycle, full error vector, root count
// and uncorrectable flag returned through a valid/ready handshake.
module bch_chien_seq
    import bch_pkg::*;
#(
    parameter int          M         = 5,
    parameter int          T         = 2,
    parameter int          P         = 1,
    parameter logic [31:0] PRIM_POLY = 32'h25
) (
    input logic           clk,
    input logic           rst,
    bch_chien_seq_if.slave bus
);
    localparam int N  = bch_n(M);
    localparam int S  = (N + P - 1) / P;
    localparam int CW = $clog2(N + 1);
    localparam int SW = (S > 1) ? $clog2(S) : 1;
    localparam int DW = $clog2(T + 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [M-1:0]    lam_q [1:T];
    logic [M-1:0]    lam_d [1:T];
    logic [M-1:0]    lam_step [1:T];
    logic [M-1:0]    lane_term [1:T][0:P-1];
    logic [M-1:0]    lane_sum [0:P-1];
    logic [DW-1:0]   deg_q, deg_d;
    logic [N-1:0]    vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            unc_q, unc_d;
    logic [P-1:0]    hit;

    // lam_q[i] holds lambda_i * alpha^(-i*k*P) at step k; lane p adds alpha^(-i*p).
    for (genvar i = 1; i <= T; i++) begin : g_coef
        gf_const_mul #(.M(M), .PRIM_POLY(PRIM_POLY), .CONST_EXP(-(i * P))) u_step (
            .a (lam_q[i]),
            .y (lam_step[i])
        );
        for (genvar p = 0; p < P; p++) begin : g_lane
            gf_const_mul #(.M(M), .PRIM_POLY(PRIM_POLY), .CONST_EXP(-(i * p))) u_lane (
                .a (lam_q[i]),
                .y (lane_term[i][p])
            );
        end
    end

    // NOTE: every combinational output gets a value before any condition, so no latch is inferred.
    always_comb begin
        hit = '0;
        for (int p = 0; p < P; p++) begin
            lane_sum[p] = M'(1);
            for (int i = 1; i <= T; i++) lane_sum[p] = lane_sum[p] ^ lane_term[i][p];
            hit[p] = (lane_sum[p] == '0) && ((int'(step_q) * P + p) < N);
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lam_d   = lam_q;
        deg_d   = deg_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        unc_d   = unc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SEARCH;
                    step_d  = '0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    unc_d   = 1'b0;
                    deg_d   = '0;
                    for (int i = 1; i <= T; i++) begin
                        lam_d[i] = bus.lambda[i*M-1 -: M];
                        if (bus.lambda[i*M-1 -: M] != '0) deg_d = DW'(i);
                    end
                end
            end
            SEARCH: begin
                for (int p = 0; p < P; p++) begin
                    if (hit[p]) vec_d[int'(step_q) * P + p] = 1'b1;
                end
                cnt_d = cnt_q + CW'(popcount(POP_W'(hit)));
                lam_d = lam_step;
                if (step_q == SW'(S - 1)) begin
                    state_d = DONE;
                    unc_d   = (32'(cnt_d) != 32'(deg_q));
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            unc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            unc_q   <= unc_d;
        end
    end

    // NOTE: coefficient/degree storage is left unreset; it is always loaded on accept before use.
    always_ff @(posedge clk) begin
        lam_q <= lam_d;
        deg_q <= deg_d;
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.error_vector  = vec_q;
    assign bus.error_found   = |vec_q;
    assign bus.err_count     = cnt_q;
    assign bus.uncorrectable = unc_q;

endmodule
